// File: rtl/fetch_stage.sv
// Instruction-fetch stage with IF/ID pipeline register.
// Owns the PC, start/halt sequencing and the post-HALT drain that raises done.
module fetch_stage #(
  parameter int              IW           = 9,
  parameter int              PCW          = 10,
  parameter logic [PCW-1:0]  RESET_PC     = '0,
  parameter logic [IW-1:0]   HALT_INSTR   = 9'h1FF,
  parameter int              DRAIN_CYCLES = 3
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic           stall,
  input  logic           branch_taken,
  input  logic [PCW-1:0] branch_target,
  output logic [PCW-1:0] imem_addr,
  input  logic [IW-1:0]  imem_data,
  output logic           if_id_valid,
  output logic [IW-1:0]  if_id_instr,
  output logic [PCW-1:0] if_id_pc,
  output logic [2:0]     if_id_rs,
  output logic [2:0]     if_id_rd,
  output logic           done
);

  localparam int CNTW = (DRAIN_CYCLES < 2) ? 1 : $clog2(DRAIN_CYCLES + 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic            vld_q, vld_d;
  logic [IW-1:0]   instr_q, instr_d;
  logic [PCW-1:0]  ifpc_q, ifpc_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic            done_q, done_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      vld_q   <= 1'b0;
      instr_q <= '0;
      ifpc_q  <= '0;
      cnt_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      vld_q   <= vld_d;
      instr_q <= instr_d;
      ifpc_q  <= ifpc_d;
      cnt_q   <= cnt_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    vld_d   = vld_q;
    instr_d = instr_q;
    ifpc_d  = ifpc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end

      S_RUN: begin
        // A redirect must win over stall, otherwise a stalled wrong-path fetch would stick.
        if (branch_taken) begin
          pc_d    = branch_target;
          vld_d   = 1'b0;
          instr_d = '0;
          ifpc_d  = '0;
        end else if (!stall) begin
          vld_d   = 1'b1;
          instr_d = imem_data;
          ifpc_d  = pc_q;
          if (imem_data == HALT_INSTR) begin
            cnt_d   = '0;
            state_d = S_DRAIN;
          end else begin
            pc_d = pc_q + 1'b1;
          end
        end
      end

      S_DRAIN: begin
        if (branch_taken) begin
          pc_d    = branch_target;
          vld_d   = 1'b0;
          instr_d = '0;
          ifpc_d  = '0;
          cnt_d   = '0;
          state_d = S_RUN;
        end else if (!stall) begin
          vld_d   = 1'b0;
          instr_d = '0;
          ifpc_d  = '0;
          // The counter value is checked before incrementing, giving 1 + DRAIN_CYCLES cycles.
          if (cnt_q == CNTW'(DRAIN_CYCLES)) begin
            done_d  = 1'b1;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end

      S_DONE: begin
        if (start) begin
          pc_d    = RESET_PC;
          done_d  = 1'b0;
          state_d = S_RUN;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign imem_addr   = pc_q;
  assign if_id_valid = vld_q;
  assign if_id_instr = instr_q;
  assign if_id_pc    = ifpc_q;
  assign if_id_rs    = instr_q[2:0];
  assign if_id_rd    = instr_q[5:3];
  assign done        = done_q;

endmodule
